cpu_decode_stage: RTL and testbench
===================================

# cpu_decode_stage

Pipeline stage directly downstream of instruction fetch. Consumes the tagged instruction/PC word fetch publishes, decodes it, reads source operands from the register file, and holds a register scoreboard so no instruction issues while a source register has an outstanding write. It presents a tagged, registered decode bundle to execute and back-pressures fetch.

## Interface
- No parameters; tag width is the shared `TAG_SIZE` range.
- i_clock  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_tag  in  TAG_SIZE  fetch output tag; a change means a new instruction is present
- i_instruction  in  32  instruction word from fetch
- i_pc  in  32  PC of i_instruction
- o_busy  out  1  drives fetch stall; high while the current input cannot be accepted
- i_stall  in  1  execute is not ready; decode outputs hold
- o_rs1_index, o_rs2_index  out  5  combinational, equal to i_instruction[19:15] and [24:20]
- i_rs1_data, i_rs2_data  in  32  asynchronous register-file read data
- i_wb_valid  in  1  one-cycle writeback pulse
- i_wb_rd  in  5  register written back
- o_tag  out  TAG_SIZE  issued-instruction tag; resets to 0
- o_op  out  4  op class: 0 ILLEGAL, 1 ALU_R, 2 ALU_I, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC, 10 SYSTEM, 11 MULDIV
- o_funct3  out  3;  o_funct7b5  out  1 (instr[30])
- o_rd  out  5;  o_rs1_data, o_rs2_data  out  32;  o_imm  out  32;  o_pc  out  32
- All registered outputs reset to 0.

## Operation
- Internal last_tag register, reset 0. The input is pending when i_tag != last_tag.
- The scoreboard is a 32-bit busy mask, reset 0. Bit 0 is never set.
- Hazard when pending and (busy[rs1] or busy[rs2]) for classes that read that source. LUI, AUIPC and JAL read none. LOAD, ALU_I and JALR read rs1 only.
- Issue condition: pending, no hazard, and !i_stall. On issue the following are registered: o_tag←i_tag, last_tag←i_tag, the decode fields, operands, and PC. busy[rd] is set if the class writes rd and rd≠0.
- Writes rd: ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC, MULDIV, and SYSTEM (CSR).
- Immediate: sign-extended I/S/B/J forms. U form is instr[31:12]<<12. Otherwise 0.
- When i_wb_valid is high, busy[i_wb_rd] is cleared. If the same cycle's issue sets the same rd, the set wins.
- Writeback is not forwarded. A source cleared this cycle issues on the next cycle. The register file is responsible for write-before-read in that next cycle.
- o_busy = pending and not issue condition (combinational).
- Unknown opcodes decode as ILLEGAL. They issue with no rd set.

## Timing
- Latency is 1 cycle: the issue cycle's inputs appear on outputs at the next edge.
- Throughput is 1 instruction per cycle with no hazards. This requires fetch to advance its tag each cycle.
- Outputs are stable until the next issue. Execute detects a new instruction by an o_tag change.
- While i_stall is high, nothing issues and the scoreboard only clears.
- A tag wrap-around is harmless because only inequality is compared.
- Reset mid-operation: the scoreboard, last_tag, and all outputs return to 0 at that edge. A fetch tag of 0 after reset is not pending.

## Configuration
- `CPU_DECODE_RV32M_EN` defined: opcode 0110011 with funct7=0000001 decodes as MULDIV, with funct3 passed through.
- Not defined: that encoding decodes as ILLEGAL and does not set the scoreboard.

## Structure
- The shared defines/package holds `TAG_SIZE`, the RV32 opcode constants, and the o_op class encodings. Execute uses the same values.
- One sub-module, cpu_scoreboard, holds the 32-bit busy mask with a set port, a clear port, and two combinational query ports.

## Test plan
- Reset, then i_tag=1, instr=0x00500093 (addi x1,x0,5), pc=0x9c. Next cycle: o_tag=1, o_op=2, o_rd=1, o_imm=5, o_pc=0x9c, busy[1]=1.
- Back-to-back addi x2,x1,1 at tag 2: o_busy=1 until i_wb_valid with rd=1. It issues one cycle after the writeback pulse.
- Instr 0xfe000ee3 (beq with negative offset): o_imm=0xfffffffc, o_op=5, no scoreboard bit set.
- i_stall held for 3 cycles with a new tag pending: o_busy high, outputs unchanged. Issue occurs in the cycle after i_stall drops.
- Same-cycle issue of rd=3 and writeback of rd=3: busy[3] remains 1.
- mul x5,x6,x7 (0x027302b3): with `CPU_DECODE_RV32M_EN` defined, o_op=11. Without it, o_op=0 and busy[5]=0.

Source files
------------

// File: rtl/cpu_decode_stage_pkg.sv
// Shared decode definitions: tag width, RV32 opcodes, op-class encodings and decode helpers.
// `CPU_DECODE_RV32M_EN` enables the MULDIV class for the M-extension encoding.
package cpu_decode_stage_pkg;

  localparam int TAG_SIZE = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
  localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_ALU_R   = 4'd1,
    OP_ALU_I   = 4'd2,
    OP_LOAD    = 4'd3,
    OP_STORE   = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_JAL     = 4'd6,
    OP_JALR    = 4'd7,
    OP_LUI     = 4'd8,
    OP_AUIPC   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_MULDIV  = 4'd11
  } op_class_e;

  function automatic op_class_e decode_class(input logic [31:0] instr);
    op_class_e cls;
    case (instr[6:0])
      OPC_LUI:    cls = OP_LUI;
      OPC_AUIPC:  cls = OP_AUIPC;
      OPC_JAL:    cls = OP_JAL;
      OPC_JALR:   cls = OP_JALR;
      OPC_BRANCH: cls = OP_BRANCH;
      OPC_LOAD:   cls = OP_LOAD;
      OPC_STORE:  cls = OP_STORE;
      OPC_ALU_I:  cls = OP_ALU_I;
      OPC_SYSTEM: cls = OP_SYSTEM;
      OPC_ALU_R: begin
        if (instr[31:25] == FUNCT7_MULDIV) begin
`ifdef CPU_DECODE_RV32M_EN
          cls = OP_MULDIV;
`else
          cls = OP_ILLEGAL;
`endif
        end else begin
          cls = OP_ALU_R;
        end
      end
      default:    cls = OP_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic writes_rd(input op_class_e cls);
    return !(cls inside {OP_STORE, OP_BRANCH, OP_ILLEGAL});
  endfunction

  // Upper-immediate and JAL forms carry no source registers.
  function automatic logic reads_rs1(input op_class_e cls);
    return !(cls inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic reads_rs2(input op_class_e cls);
    return !(cls inside {OP_LUI, OP_AUIPC, OP_JAL, OP_LOAD, OP_ALU_I, OP_JALR});
  endfunction

  function automatic logic [31:0] decode_imm(input op_class_e cls, input logic [31:0] instr);
    logic [31:0] imm;
    case (cls)
      OP_ALU_I, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_JAL:
        imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'd0};
      default:
        imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/cpu_decode_stage_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, x0 never busy.
module cpu_scoreboard
  import cpu_decode_stage_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_set_en,
  input  logic [4:0] i_set_idx,
  input  logic       i_clr_en,
  input  logic [4:0] i_clr_idx,
  input  logic [4:0] i_q1_idx,
  output logic       o_q1_busy,
  input  logic [4:0] i_q2_idx,
  output logic       o_q2_busy
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Set is applied after clear so an issuing writer keeps its bit.
  always_comb begin
    busy_d = busy_q;
    if (i_clr_en) busy_d[i_clr_idx] = 1'b0;
    if (i_set_en) busy_d[i_set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign o_q1_busy = busy_q[i_q1_idx];
  assign o_q2_busy = busy_q[i_q2_idx];

endmodule

// File: rtl/cpu_decode_stage.sv
// Decode stage: tag-handshaked intake from fetch, scoreboard interlock, registered bundle to execute.
// `CPU_DECODE_RV32M_EN` enables MULDIV decode (see package).
module cpu_decode_stage
  import cpu_decode_stage_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [TAG_SIZE-1:0] i_tag,
  input  logic [31:0]         i_instruction,
  input  logic [31:0]         i_pc,
  output logic                o_busy,
  input  logic                i_stall,
  output logic [4:0]          o_rs1_index,
  output logic [4:0]          o_rs2_index,
  input  logic [31:0]         i_rs1_data,
  input  logic [31:0]         i_rs2_data,
  input  logic                i_wb_valid,
  input  logic [4:0]          i_wb_rd,
  output logic [TAG_SIZE-1:0] o_tag,
  output logic [3:0]          o_op,
  output logic [2:0]          o_funct3,
  output logic                o_funct7b5,
  output logic [4:0]          o_rd,
  output logic [31:0]         o_rs1_data,
  output logic [31:0]         o_rs2_data,
  output logic [31:0]         o_imm,
  output logic [31:0]         o_pc
);

  logic [TAG_SIZE-1:0] last_tag_q, last_tag_d;
  op_class_e           op_q, op_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                funct7b5_q, funct7b5_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         rs1_data_q, rs1_data_d;
  logic [31:0]         rs2_data_q, rs2_data_d;
  logic [31:0]         imm_q, imm_d;
  logic [31:0]         pc_q, pc_d;

  op_class_e cls;
  logic      pending;
  logic      hazard;
  logic      issue;
  logic      set_en;
  logic      rs1_busy;
  logic      rs2_busy;

  assign o_rs1_index = i_instruction[19:15];
  assign o_rs2_index = i_instruction[24:20];

  cpu_scoreboard u_scoreboard (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_set_en  (set_en),
    .i_set_idx (i_instruction[11:7]),
    .i_clr_en  (i_wb_valid),
    .i_clr_idx (i_wb_rd),
    .i_q1_idx  (i_instruction[19:15]),
    .o_q1_busy (rs1_busy),
    .i_q2_idx  (i_instruction[24:20]),
    .o_q2_busy (rs2_busy)
  );

  // Only inequality against the last issued tag matters, so tag wrap is harmless.
  always_comb begin
    cls     = decode_class(i_instruction);
    pending = (i_tag != last_tag_q);
    hazard  = pending && ((reads_rs1(cls) && rs1_busy) || (reads_rs2(cls) && rs2_busy));
    issue   = pending && !hazard && !i_stall;
    set_en  = issue && writes_rd(cls) && (i_instruction[11:7] != 5'd0);
    o_busy  = pending && !issue;

    last_tag_d = last_tag_q;
    op_d       = op_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    if (issue) begin
      last_tag_d = i_tag;
      op_d       = cls;
      funct3_d   = i_instruction[14:12];
      funct7b5_d = i_instruction[30];
      rd_d       = i_instruction[11:7];
      rs1_data_d = i_rs1_data;
      rs2_data_d = i_rs2_data;
      imm_d      = decode_imm(cls, i_instruction);
      pc_d       = i_pc;
    end
  end

  // Issue boundary: decode bundle registered toward execute.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_tag_q <= '0;
      op_q       <= OP_ILLEGAL;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      last_tag_q <= last_tag_d;
      op_q       <= op_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
    end
  end

  assign o_tag      = last_tag_q;
  assign o_op       = op_q;
  assign o_funct3   = funct3_q;
  assign o_funct7b5 = funct7b5_q;
  assign o_rd       = rd_q;
  assign o_rs1_data = rs1_data_q;
  assign o_rs2_data = rs2_data_q;
  assign o_imm      = imm_q;
  assign o_pc       = pc_q;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Bench for cpu_decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_cpu_decode_stage;

  localparam int TW = 4;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic [TW-1:0] i_tag = '0;
  logic [31:0]   i_instruction = '0;
  logic [31:0]   i_pc = '0;
  logic          o_busy;
  logic          i_stall = 1'b0;
  logic [4:0]    o_rs1_index, o_rs2_index;
  logic [31:0]   i_rs1_data = '0, i_rs2_data = '0;
  logic          i_wb_valid = 1'b0;
  logic [4:0]    i_wb_rd = '0;
  logic [TW-1:0] o_tag;
  logic [3:0]    o_op;
  logic [2:0]    o_funct3;
  logic          o_funct7b5;
  logic [4:0]    o_rd;
  logic [31:0]   o_rs1_data, o_rs2_data, o_imm, o_pc;

  cpu_decode_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tag(i_tag), .i_instruction(i_instruction),
    .i_pc(i_pc), .o_busy(o_busy), .i_stall(i_stall), .o_rs1_index(o_rs1_index),
    .o_rs2_index(o_rs2_index), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .o_tag(o_tag), .o_op(o_op),
    .o_funct3(o_funct3), .o_funct7b5(o_funct7b5), .o_rd(o_rd), .o_rs1_data(o_rs1_data),
    .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_pc(o_pc)
  );

  always #5 i_clock = ~i_clock;

`ifdef CPU_DECODE_RV32M_EN
  localparam int MUL_OP = 11;
`else
  localparam int MUL_OP = 0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [TW-1:0] m_last_tag;
  logic [31:0]   m_busy;
  int            m_op;
  logic [2:0]    m_f3;
  logic          m_f7b5;
  logic [4:0]    m_rd;
  logic [31:0]   m_rs1d, m_rs2d, m_imm, m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Class, rd-write, source usage and immediate straight from the ISA tables.
  function automatic void mdl_decode(input logic [31:0] ins, output int cls, output bit wr,
                                     output bit r1, output bit r2, output logic [31:0] imm);
    logic [31:0] i_imm;
    i_imm = 32'($signed(ins) >>> 20);
    imm = 32'd0;
    case (ins[6:0])
      7'h37: begin cls = 8;  wr = 1; r1 = 0; r2 = 0; imm = ins & 32'hfffff000; end
      7'h17: begin cls = 9;  wr = 1; r1 = 0; r2 = 0; imm = ins & 32'hfffff000; end
      7'h6f: begin cls = 6;  wr = 1; r1 = 0; r2 = 0;
                   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h67: begin cls = 7;  wr = 1; r1 = 1; r2 = 0; imm = i_imm; end
      7'h63: begin cls = 5;  wr = 0; r1 = 1; r2 = 1;
                   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h03: begin cls = 3;  wr = 1; r1 = 1; r2 = 0; imm = i_imm; end
      7'h23: begin cls = 4;  wr = 0; r1 = 1; r2 = 1; imm = {i_imm[31:5], ins[11:7]}; end
      7'h13: begin cls = 2;  wr = 1; r1 = 1; r2 = 0; imm = i_imm; end
      7'h73: begin cls = 10; wr = 1; r1 = 1; r2 = 1; imm = i_imm; end
      7'h33: begin
        r1 = 1; r2 = 1;
        if (ins[31:25] == 7'h01) begin cls = MUL_OP; wr = (MUL_OP != 0); end
        else begin cls = 1; wr = 1; end
      end
      default: begin cls = 0; wr = 0; r1 = 1; r2 = 1; end
    endcase
  endfunction

  task automatic check_outputs();
    chk("o_tag", 32'(o_tag), 32'(m_last_tag));
    chk("o_op", 32'(o_op), 32'(m_op));
    chk("o_funct3", 32'(o_funct3), 32'(m_f3));
    chk("o_funct7b5", 32'(o_funct7b5), 32'(m_f7b5));
    chk("o_rd", 32'(o_rd), 32'(m_rd));
    chk("o_rs1_data", o_rs1_data, m_rs1d);
    chk("o_rs2_data", o_rs2_data, m_rs2d);
    chk("o_imm", o_imm, m_imm);
    chk("o_pc", o_pc, m_pc);
    chk("busy_mask", dut.u_scoreboard.busy_q, m_busy);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_tag = '0; i_stall = 1'b0; i_wb_valid = 1'b0;
    @(posedge i_clock); #1;
    m_last_tag = '0; m_busy = '0; m_op = 0; m_f3 = '0; m_f7b5 = 1'b0; m_rd = '0;
    m_rs1d = '0; m_rs2d = '0; m_imm = '0; m_pc = '0;
    check_outputs();
    i_reset = 1'b0;
  endtask

  // Starts just after a rising edge; ends just after the next one.
  task automatic run_cycle(input logic [TW-1:0] tag, input logic [31:0] ins, input logic [31:0] pc,
                           input bit stall, input bit wbv, input logic [4:0] wbrd, output bit iss);
    int cls; bit wr, r1, r2, pend, haz; logic [31:0] imm, nb;
    i_tag = tag; i_instruction = ins; i_pc = pc; i_stall = stall;
    i_wb_valid = wbv; i_wb_rd = wbrd;
    i_rs1_data = $urandom; i_rs2_data = $urandom;
    #1;
    mdl_decode(ins, cls, wr, r1, r2, imm);
    pend = (tag != m_last_tag);
    haz  = pend && ((r1 && m_busy[ins[19:15]]) || (r2 && m_busy[ins[24:20]]));
    iss  = pend && !haz && !stall;
    chk("o_busy", 32'(o_busy), 32'(pend && !iss));
    chk("o_rs1_index", 32'(o_rs1_index), 32'(ins[19:15]));
    chk("o_rs2_index", 32'(o_rs2_index), 32'(ins[24:20]));
    nb = m_busy;
    if (wbv) nb[wbrd] = 1'b0;
    if (iss && wr && ins[11:7] != 5'd0) nb[ins[11:7]] = 1'b1;
    m_busy = nb;
    if (iss) begin
      m_last_tag = tag; m_op = cls; m_f3 = ins[14:12]; m_f7b5 = ins[30]; m_rd = ins[11:7];
      m_rs1d = i_rs1_data; m_rs2d = i_rs2_data; m_imm = imm; m_pc = pc;
    end
    @(posedge i_clock); #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h73, 7'h7f, 7'h0b};
    logic [31:0] ins;
    ins = $urandom;
    ins[6:0]   = opcs[$urandom_range(0, 11)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    if (ins[6:0] == 7'h33)
      ins[31:25] = ($urandom_range(0, 3) == 0) ? 7'h01 : {1'b0, ins[30], 5'd0};
    return ins;
  endfunction

  initial begin
    bit          iss;
    logic [TW-1:0] cur_tag;
    logic [31:0] cur_ins, cur_pc;
    bit          wbv;
    logic [4:0]  wbrd;
    int          start;

    do_reset();
    run_cycle(4'd0, 32'h00500093, 32'h9c, 0, 0, 5'd0, iss);      // tag 0 after reset: idle

    run_cycle(4'd1, 32'h00500093, 32'h9c, 0, 0, 5'd0, iss);
    chk("addi_tag", 32'(o_tag), 32'd1);
    chk("addi_op", 32'(o_op), 32'd2);
    chk("addi_rd", 32'(o_rd), 32'd1);
    chk("addi_imm", o_imm, 32'd5);
    chk("addi_pc", o_pc, 32'h9c);
    chk("addi_busy1", 32'(dut.u_scoreboard.busy_q[1]), 32'd1);

    run_cycle(4'd2, 32'h00108113, 32'ha0, 0, 0, 5'd0, iss);
    chk("raw_hold1", 32'(o_tag), 32'd1);
    run_cycle(4'd2, 32'h00108113, 32'ha0, 0, 1, 5'd1, iss);
    chk("raw_wb_cycle", 32'(o_tag), 32'd1);
    run_cycle(4'd2, 32'h00108113, 32'ha0, 0, 0, 5'd0, iss);
    chk("raw_issue_tag", 32'(o_tag), 32'd2);

    run_cycle(4'd3, 32'hfe000ee3, 32'ha4, 0, 0, 5'd0, iss);
    chk("beq_imm", o_imm, 32'hfffffffc);
    chk("beq_op", 32'(o_op), 32'd5);
    chk("beq_mask", dut.u_scoreboard.busy_q, 32'h4);

    for (int k = 0; k < 3; k++) begin
      run_cycle(4'd4, 32'h00000233, 32'ha8, 1, 0, 5'd0, iss);
      chk("stall_hold", 32'(o_tag), 32'd3);
    end
    run_cycle(4'd4, 32'h00000233, 32'ha8, 0, 0, 5'd0, iss);
    chk("stall_release", 32'(o_tag), 32'd4);

    run_cycle(4'd5, 32'h00700193, 32'hac, 0, 0, 5'd0, iss);
    run_cycle(4'd6, 32'h00100193, 32'hb0, 0, 1, 5'd3, iss);
    chk("set_wins", 32'(dut.u_scoreboard.busy_q[3]), 32'd1);

    run_cycle(4'd7, 32'h027302b3, 32'hb4, 0, 0, 5'd0, iss);
    chk("mul_op", 32'(o_op), 32'(MUL_OP));
    chk("mul_busy5", 32'(dut.u_scoreboard.busy_q[5]), 32'(MUL_OP != 0));

    cur_tag = 4'd7; cur_ins = 32'h027302b3; cur_pc = 32'hb4;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        do_reset();
        cur_tag = '0;
      end
      if (cur_tag == m_last_tag && $urandom_range(0, 3) != 0) begin
        cur_tag = cur_tag + 1'b1;
        cur_ins = rand_instr();
        cur_pc  = cur_pc + 32'd4;
      end
      wbv = 0; wbrd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        start = $urandom_range(1, 31);
        for (int k = 0; k < 32; k++) begin
          if (!wbv && m_busy[(start + k) % 32]) begin
            wbv = 1; wbrd = 5'((start + k) % 32);
          end
        end
      end
      run_cycle(cur_tag, cur_ins, cur_pc, ($urandom_range(0, 4) == 0), wbv, wbrd, iss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
